cam_slot_ctrl: RTL and testbench



---
 rtl/cam_slot_ctrl_pkg.sv | 33 +++
 rtl/cam_slot_ctrl_if.sv | 57 +++++
 rtl/cam_slot_ctrl_lowest_free_enc.sv | 23 ++
 rtl/cam_slot_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cam_slot_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_slot_ctrl_pkg.sv
// rtl/cam_slot_ctrl_pkg.sv - shared types and sizes for the tag CAM slot controller
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package cam_slot_ctrl_pkg;

  localparam int CMD_ID_WIDTH  = 8;
  typedef logic [CMD_ID_WIDTH-1:0] cmd_id_t;

  localparam int PROC_ID_WIDTH = $clog2(`PROC_COUNT);
  localparam int DATA_WIDTH    = $bits(cmd_id_t) + PROC_ID_WIDTH;
  localparam int ADDR_WIDTH    = $clog2(`PROC_COUNT) + 1;
  localparam int NUM_SLOTS     = 2 ** ADDR_WIDTH;
  localparam int OCC_WIDTH     = ADDR_WIDTH + 1;

  // Key layout as stored in the CAM: cmd_id in the upper bits, proc_id below.
  typedef struct packed {
    cmd_id_t                  cmd_id;
    logic [PROC_ID_WIDTH-1:0] proc_id;
  } cam_key_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    LK_WAIT,
    DEL_ISSUE,
    DEL_WAIT,
    Q_RESP
  } cam_slot_state_t;

endpackage

// File: rtl/cam_slot_ctrl_if.sv
// rtl/cam_slot_ctrl_if.sv - requester handshakes, CAM port and status bundle
interface cam_slot_ctrl_if;
  import cam_slot_ctrl_pkg::*;

  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] ins_data;
  logic [ADDR_WIDTH-1:0] ins_addr;

  logic                  ret_valid;
  logic                  ret_ready;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  ret_done;
  logic                  ret_miss;

  logic                  qry_valid;
  logic                  qry_ready;
  logic [DATA_WIDTH-1:0] qry_data;
  logic                  qry_resp_valid;
  logic                  qry_hit;
  logic [ADDR_WIDTH-1:0] qry_addr;

  logic [ADDR_WIDTH-1:0] cam_write_addr;
  logic [DATA_WIDTH-1:0] cam_write_data;
  logic                  cam_write_enable;
  logic                  cam_write_delete;
  logic [DATA_WIDTH-1:0] cam_compare_data;
  logic                  cam_write_busy;
  logic                  cam_match;
  logic [ADDR_WIDTH-1:0] cam_match_addr;
  logic                  cam_reset;

  logic [OCC_WIDTH-1:0]  occupancy;
  logic                  full;
  logic                  empty;

  // Controller side: owns the CAM strobes and all responses.
  modport slave (
    input  ins_valid, ins_data, ret_valid, ret_data, qry_valid, qry_data,
    input  cam_write_busy, cam_match, cam_match_addr,
    output ins_ready, ins_addr, ret_ready, ret_done, ret_miss,
    output qry_ready, qry_resp_valid, qry_hit, qry_addr,
    output cam_write_addr, cam_write_data, cam_write_enable, cam_write_delete,
    output cam_compare_data, cam_reset, occupancy, full, empty
  );

  // Requester and CAM side.
  modport master (
    output ins_valid, ins_data, ret_valid, ret_data, qry_valid, qry_data,
    output cam_write_busy, cam_match, cam_match_addr,
    input  ins_ready, ins_addr, ret_ready, ret_done, ret_miss,
    input  qry_ready, qry_resp_valid, qry_hit, qry_addr,
    input  cam_write_addr, cam_write_data, cam_write_enable, cam_write_delete,
    input  cam_compare_data, cam_reset, occupancy, full, empty
  );

endinterface

// File: rtl/cam_slot_ctrl_lowest_free_enc.sv
// rtl/cam_slot_ctrl_lowest_free_enc.sv - lowest clear bit finder for the slot bitmap
module lowest_free_enc #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]  bitmap,
  output logic [AW-1:0] free_idx,
  output logic          none_free
);

  // Scan from the top down so the last hit taken is the lowest clear index.
  always_comb begin
    free_idx  = '0;
    none_free = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_idx  = AW'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_slot_ctrl.sv
// rtl/cam_slot_ctrl.sv - slot allocator and access sequencer for the tag CAM
module cam_slot_ctrl
  import cam_slot_ctrl_pkg::*;
#(
  parameter int LOOKUP_LAT   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  cam_slot_ctrl_if.slave   bus
);

  localparam int LK_W = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);
  localparam int SV_W = $clog2(STARVE_LIMIT + 1);

  cam_slot_state_t       state_q, state_d;
  logic [NUM_SLOTS-1:0]  bitmap_q, bitmap_d;
  logic [OCC_WIDTH-1:0]  occupancy_q, occupancy_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [SV_W-1:0]       starve_q, starve_d;
  logic [LK_W-1:0]       lk_cnt_q, lk_cnt_d;
  logic                  lk_is_ret_q, lk_is_ret_d;
  logic [ADDR_WIDTH-1:0] cam_write_addr_q, cam_write_addr_d;
  logic [DATA_WIDTH-1:0] cam_write_data_q, cam_write_data_d;
  logic                  cam_write_enable_q, cam_write_enable_d;
  logic                  cam_write_delete_q, cam_write_delete_d;
  logic [DATA_WIDTH-1:0] cam_compare_data_q, cam_compare_data_d;
  logic                  ret_done_q, ret_done_d;
  logic                  ret_miss_q, ret_miss_d;
  logic                  qry_resp_valid_q, qry_resp_valid_d;
  logic                  qry_hit_q, qry_hit_d;
  logic [ADDR_WIDTH-1:0] qry_addr_q, qry_addr_d;

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  none_free;
  logic                  idle;
  logic                  ins_force;
  logic                  ret_gnt;
  logic                  qry_gnt;
  logic                  ins_gnt;
  logic                  lk_hit;

  lowest_free_enc #(
    .N  (NUM_SLOTS),
    .AW (ADDR_WIDTH)
  ) u_free_enc (
    .bitmap    (bitmap_q),
    .free_idx  (free_idx),
    .none_free (none_free)
  );

  // Grants are only offered from IDLE and never while reset is held.
  assign idle      = (state_q == IDLE) && rst;
  assign ins_force = bus.ins_valid && !full_q && (starve_q == SV_W'(STARVE_LIMIT));
  assign ret_gnt   = idle && bus.ret_valid && !ins_force;
  assign qry_gnt   = idle && bus.qry_valid && !bus.ret_valid && !ins_force;
  assign ins_gnt   = idle && bus.ins_valid && !full_q && !none_free &&
                     (ins_force || (!bus.ret_valid && !bus.qry_valid));

  // A match only counts if the slot is still allocated in our bitmap.
  assign lk_hit = bus.cam_match && bitmap_q[bus.cam_match_addr];

  assign bus.ins_ready        = ins_gnt;
  assign bus.ret_ready        = ret_gnt;
  assign bus.qry_ready        = qry_gnt;
  assign bus.ins_addr         = free_idx;
  assign bus.ret_done         = ret_done_q;
  assign bus.ret_miss         = ret_miss_q;
  assign bus.qry_resp_valid   = qry_resp_valid_q;
  assign bus.qry_hit          = qry_hit_q;
  assign bus.qry_addr         = qry_addr_q;
  assign bus.cam_write_addr   = cam_write_addr_q;
  assign bus.cam_write_data   = cam_write_data_q;
  assign bus.cam_write_enable = cam_write_enable_q;
  assign bus.cam_write_delete = cam_write_delete_q;
  assign bus.cam_compare_data = cam_compare_data_q;
  assign bus.cam_reset        = ~rst;
  assign bus.occupancy        = occupancy_q;
  assign bus.full             = full_q;
  assign bus.empty            = empty_q;

  // Next-state, bitmap bookkeeping, starvation counter and CAM strobes.
  always_comb begin
    state_d            = state_q;
    bitmap_d           = bitmap_q;
    occupancy_d        = occupancy_q;
    lk_cnt_d           = lk_cnt_q;
    lk_is_ret_d        = lk_is_ret_q;
    cam_write_addr_d   = cam_write_addr_q;
    cam_write_data_d   = cam_write_data_q;
    cam_compare_data_d = cam_compare_data_q;
    qry_hit_d          = qry_hit_q;
    qry_addr_d         = qry_addr_q;
    cam_write_enable_d = 1'b0;
    cam_write_delete_d = 1'b0;
    ret_done_d         = 1'b0;
    ret_miss_d         = 1'b0;
    qry_resp_valid_d   = 1'b0;

    starve_d = starve_q;
    if (!bus.ins_valid || ins_gnt) begin
      starve_d = '0;
    end else if ((ret_gnt || qry_gnt) && (starve_q != SV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (ret_gnt) begin
          cam_compare_data_d = bus.ret_data;
          lk_is_ret_d        = 1'b1;
          lk_cnt_d           = '0;
          state_d            = LK_WAIT;
        end else if (qry_gnt) begin
          cam_compare_data_d = bus.qry_data;
          lk_is_ret_d        = 1'b0;
          lk_cnt_d           = '0;
          state_d            = LK_WAIT;
        end else if (ins_gnt) begin
          bitmap_d[free_idx] = 1'b1;
          occupancy_d        = occupancy_q + OCC_WIDTH'(1);
          cam_write_addr_d   = free_idx;
          cam_write_data_d   = bus.ins_data;
          cam_write_enable_d = 1'b1;
          state_d            = WR_ISSUE;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (!bus.cam_write_busy) state_d = IDLE;
      end
      LK_WAIT: begin
        if (lk_cnt_q == LK_W'(LOOKUP_LAT)) begin
          if (lk_is_ret_q) begin
            if (lk_hit) begin
              cam_write_addr_d   = bus.cam_match_addr;
              cam_write_delete_d = 1'b1;
              state_d            = DEL_ISSUE;
            end else begin
              ret_miss_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            qry_resp_valid_d = 1'b1;
            qry_hit_d        = lk_hit;
            qry_addr_d       = lk_hit ? bus.cam_match_addr : '0;
            state_d          = Q_RESP;
          end
        end else begin
          lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
      end
      DEL_ISSUE: begin
        bitmap_d[cam_write_addr_q] = 1'b0;
        occupancy_d                = occupancy_q - OCC_WIDTH'(1);
        state_d                    = DEL_WAIT;
      end
      DEL_WAIT: begin
        if (!bus.cam_write_busy) begin
          ret_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      Q_RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    full_d  = (occupancy_d == OCC_WIDTH'(NUM_SLOTS));
    empty_d = (occupancy_d == '0);
  end

  // Single register stage for FSM state and every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      bitmap_q           <= '0;
      occupancy_q        <= '0;
      full_q             <= 1'b0;
      empty_q            <= 1'b1;
      starve_q           <= '0;
      lk_cnt_q           <= '0;
      lk_is_ret_q        <= 1'b0;
      cam_write_addr_q   <= '0;
      cam_write_data_q   <= '0;
      cam_write_enable_q <= 1'b0;
      cam_write_delete_q <= 1'b0;
      cam_compare_data_q <= '0;
      ret_done_q         <= 1'b0;
      ret_miss_q         <= 1'b0;
      qry_resp_valid_q   <= 1'b0;
      qry_hit_q          <= 1'b0;
      qry_addr_q         <= '0;
    end else begin
      state_q            <= state_d;
      bitmap_q           <= bitmap_d;
      occupancy_q        <= occupancy_d;
      full_q             <= full_d;
      empty_q            <= empty_d;
      starve_q           <= starve_d;
      lk_cnt_q           <= lk_cnt_d;
      lk_is_ret_q        <= lk_is_ret_d;
      cam_write_addr_q   <= cam_write_addr_d;
      cam_write_data_q   <= cam_write_data_d;
      cam_write_enable_q <= cam_write_enable_d;
      cam_write_delete_q <= cam_write_delete_d;
      cam_compare_data_q <= cam_compare_data_d;
      ret_done_q         <= ret_done_d;
      ret_miss_q         <= ret_miss_d;
      qry_resp_valid_q   <= qry_resp_valid_d;
      qry_hit_q          <= qry_hit_d;
      qry_addr_q         <= qry_addr_d;
    end
  end

endmodule

// File: tb/tb_cam_slot_ctrl.sv
// tb/tb_cam_slot_ctrl.sv - directed self-checking bench for cam_slot_ctrl
module tb_cam_slot_ctrl;
  import cam_slot_ctrl_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cam_slot_ctrl_if bus ();

  cam_slot_ctrl #(
    .LOOKUP_LAT   (1),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM: registered compare, one cycle of lookup latency.
  logic [DW-1:0]        cam_mem [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] cam_vld;

  always @(posedge clk) begin
    logic          hit;
    logic [AW-1:0] a;
    if (bus.cam_reset) begin
      cam_vld <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) cam_mem[i] <= '0;
      bus.cam_match      <= 1'b0;
      bus.cam_match_addr <= '0;
    end else begin
      if (bus.cam_write_enable) begin
        cam_mem[bus.cam_write_addr] <= bus.cam_write_data;
        cam_vld[bus.cam_write_addr] <= 1'b1;
      end
      if (bus.cam_write_delete) cam_vld[bus.cam_write_addr] <= 1'b0;
      hit = 1'b0;
      a   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == bus.cam_compare_data) begin
          hit = 1'b1;
          a   = AW'(i);
        end
      end
      bus.cam_match      <= hit;
      bus.cam_match_addr <= a;
    end
  end

  function automatic cam_key_t mk_key(input int cmd, input int proc);
    cam_key_t k;
    k.cmd_id  = cmd_id_t'(cmd);
    k.proc_id = PROC_ID_WIDTH'(proc);
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input cam_key_t key, output logic [AW-1:0] addr, output logic we_now,
                           output logic [AW-1:0] we_addr, output logic [DW-1:0] we_data,
                           output logic we_after, output logic timeout);
    logic got;
    got  = 1'b0;
    addr = '0;
    bus.ins_valid = 1'b1;
    bus.ins_data  = key;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (bus.ins_ready) begin
        got  = 1'b1;
        addr = bus.ins_addr;
      end
      tick();
    end
    bus.ins_valid = 1'b0;
    we_now  = bus.cam_write_enable;
    we_addr = bus.cam_write_addr;
    we_data = bus.cam_write_data;
    tick();
    we_after = bus.cam_write_enable;
    tick();
    timeout = !got;
  endtask

  task automatic do_retire(input cam_key_t key, output logic done, output logic miss,
                           output logic del_seen, output logic [AW-1:0] del_addr,
                           output logic timeout);
    logic got;
    got = 1'b0;
    bus.ret_valid = 1'b1;
    bus.ret_data  = key;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (bus.ret_ready) got = 1'b1;
      tick();
    end
    bus.ret_valid = 1'b0;
    done = 1'b0; miss = 1'b0; del_seen = 1'b0; del_addr = '0;
    for (int i = 0; i < 50 && got && !done && !miss; i++) begin
      if (bus.cam_write_delete) begin
        del_seen = 1'b1;
        del_addr = bus.cam_write_addr;
      end
      if (bus.ret_done) done = 1'b1;
      if (bus.ret_miss) miss = 1'b1;
      if (!done && !miss) tick();
    end
    timeout = !got || (!done && !miss);
  endtask

  task automatic do_query(input cam_key_t key, output logic hit, output logic [AW-1:0] addr,
                          output logic timeout);
    logic got;
    logic seen;
    got = 1'b0; seen = 1'b0; hit = 1'b0; addr = '0;
    bus.qry_valid = 1'b1;
    bus.qry_data  = key;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (bus.qry_ready) got = 1'b1;
      tick();
    end
    bus.qry_valid = 1'b0;
    for (int i = 0; i < 50 && got && !seen; i++) begin
      if (bus.qry_resp_valid) begin
        seen = 1'b1;
        hit  = bus.qry_hit;
        addr = bus.qry_addr;
      end
      tick();
    end
    timeout = !seen;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if ({bus.cam_write_enable, bus.cam_write_delete, bus.ret_done, bus.ret_miss, bus.qry_resp_valid} !== 5'b0)
      begin failures++; $display("FAIL reset_pulses: got %b expected 00000", {bus.cam_write_enable, bus.cam_write_delete, bus.ret_done, bus.ret_miss, bus.qry_resp_valid}); end
    checks++; if (bus.cam_compare_data !== '0) begin failures++; $display("FAIL reset_compare_data: got %0h expected 0", bus.cam_compare_data); end
    bus.ins_valid = 1'b1;
    bus.ins_data  = mk_key(1, 2);
    #1;
    checks++; if (bus.ins_ready !== 1'b0) begin failures++; $display("FAIL reset_ins_ready: got %b expected 0", bus.ins_ready); end
    bus.ins_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a, wa, da;
    logic [DW-1:0] wd;
    logic we, wa2, to, dn, ms, ds;
    bus.cam_write_busy = 1'b1;
    do_insert(mk_key(7, 0), a, we, wa, wd, wa2, to);
    checks++; if (to !== 1'b0 || bus.occupancy !== OCC_WIDTH'(1))
      begin failures++; $display("FAIL midrst_pre_occupancy: got %0d expected 1 (timeout %b)", bus.occupancy, to); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL midrst_occupancy: got %0d expected 0", bus.occupancy); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL midrst_flags: got empty=%b full=%b expected 1 0", bus.empty, bus.full); end
    checks++; if (bus.cam_write_addr !== '0 || bus.cam_write_data !== '0 || bus.cam_reset !== 1'b1)
      begin failures++; $display("FAIL midrst_cam_port: got addr=%0d data=%0h cam_reset=%b expected 0 0 1", bus.cam_write_addr, bus.cam_write_data, bus.cam_reset); end
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.cam_write_busy = 1'b0;
    rst = 1'b1;
    tick();
    do_retire(mk_key(5, 1), dn, ms, ds, da, to);
    checks++; if (to !== 1'b0 || ms !== 1'b1 || ds !== 1'b0)
      begin failures++; $display("FAIL retire_empty: got miss=%b delete=%b timeout=%b expected 1 0 0", ms, ds, to); end
  endtask

  task automatic test_insert();
    logic [AW-1:0] a, wa;
    logic [DW-1:0] wd, exp_key;
    logic we, we_after, to;
    exp_key = mk_key(1, 2);
    do_insert(mk_key(1, 2), a, we, wa, wd, we_after, to);
    checks++; if (to !== 1'b0 || a !== '0) begin failures++; $display("FAIL insert_addr: got %0d expected 0 (timeout %b)", a, to); end
    checks++; if (we !== 1'b1 || we_after !== 1'b0) begin failures++; $display("FAIL insert_we_pulse: got %b%b expected 10", we, we_after); end
    checks++; if (wa !== '0 || wd !== exp_key) begin failures++; $display("FAIL insert_cam_write: got addr=%0d data=%0h expected 0 %0h", wa, wd, exp_key); end
    checks++; if (bus.occupancy !== OCC_WIDTH'(1) || bus.empty !== 1'b0)
      begin failures++; $display("FAIL insert_occupancy: got %0d empty=%b expected 1 0", bus.occupancy, bus.empty); end
  endtask

  task automatic test_query();
    logic h;
    logic [AW-1:0] a;
    logic to;
    do_query(mk_key(1, 2), h, a, to);
    checks++; if (to !== 1'b0 || h !== 1'b1 || a !== '0) begin failures++; $display("FAIL query_hit: got hit=%b addr=%0d expected 1 0 (timeout %b)", h, a, to); end
    do_query(mk_key(1, 3), h, a, to);
    checks++; if (to !== 1'b0 || h !== 1'b0 || a !== '0) begin failures++; $display("FAIL query_miss: got hit=%b addr=%0d expected 0 0 (timeout %b)", h, a, to); end
  endtask

  task automatic test_retire_miss();
    logic dn, ms, ds, to;
    logic [AW-1:0] da;
    do_retire(mk_key(11, 2), dn, ms, ds, da, to);
    checks++; if (to !== 1'b0 || ms !== 1'b1 || dn !== 1'b0) begin failures++; $display("FAIL retire_miss: got miss=%b done=%b expected 1 0 (timeout %b)", ms, dn, to); end
    checks++; if (ds !== 1'b0) begin failures++; $display("FAIL retire_miss_no_delete: got %b expected 0", ds); end
    checks++; if (bus.occupancy !== OCC_WIDTH'(1)) begin failures++; $display("FAIL retire_miss_occupancy: got %0d expected 1", bus.occupancy); end
  endtask

  task automatic test_fill();
    logic [AW-1:0] a, wa, da;
    logic [DW-1:0] wd;
    logic we, wa2, to, seen, dn, ms, ds;
    for (int i = 1; i < NUM_SLOTS; i++) begin
      do_insert(mk_key(20 + i, i % 4), a, we, wa, wd, wa2, to);
      checks++; if (to !== 1'b0 || a !== AW'(i)) begin failures++; $display("FAIL fill_addr_%0d: got %0d expected %0d (timeout %b)", i, a, i, to); end
    end
    checks++; if (bus.full !== 1'b1 || bus.occupancy !== OCC_WIDTH'(8)) begin failures++; $display("FAIL fill_full: got full=%b occ=%0d expected 1 8", bus.full, bus.occupancy); end
    seen = 1'b0;
    bus.ins_valid = 1'b1;
    bus.ins_data  = mk_key(99, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.ins_ready) seen = 1'b1;
      tick();
    end
    bus.ins_valid = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL full_ins_ready: got %b expected 0", seen); end
    do_retire(mk_key(25, 1), dn, ms, ds, da, to);
    checks++; if (to !== 1'b0 || dn !== 1'b1 || ds !== 1'b1 || da !== AW'(5))
      begin failures++; $display("FAIL retire_slot5: got done=%b delete=%b addr=%0d expected 1 1 5 (timeout %b)", dn, ds, da, to); end
    checks++; if (bus.occupancy !== OCC_WIDTH'(7) || bus.full !== 1'b0) begin failures++; $display("FAIL retire_slot5_occ: got %0d full=%b expected 7 0", bus.occupancy, bus.full); end
    do_insert(mk_key(30, 3), a, we, wa, wd, wa2, to);
    checks++; if (to !== 1'b0 || a !== AW'(5)) begin failures++; $display("FAIL reuse_slot5: got %0d expected 5 (timeout %b)", a, to); end
  endtask

  task automatic test_starve();
    int n_ret;
    logic got, del, dn, ms, ds, to;
    logic [AW-1:0] a, da;
    do_retire(mk_key(1, 2), dn, ms, ds, da, to);
    checks++; if (to !== 1'b0 || dn !== 1'b1 || da !== '0) begin failures++; $display("FAIL starve_setup: got done=%b addr=%0d expected 1 0", dn, da); end
    n_ret = 0; got = 1'b0; del = 1'b0; a = '0;
    bus.ret_valid = 1'b1;
    bus.ret_data  = mk_key(11, 2);
    bus.ins_valid = 1'b1;
    bus.ins_data  = mk_key(40, 0);
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (bus.cam_write_delete) del = 1'b1;
      if (bus.ins_ready) begin
        got = 1'b1;
        a   = bus.ins_addr;
      end else if (bus.ret_ready) begin
        n_ret++;
      end
      tick();
    end
    bus.ret_valid = 1'b0;
    bus.ins_valid = 1'b0;
    checks++; if (got !== 1'b1 || n_ret != 4) begin failures++; $display("FAIL starve_grants: got %0d retire grants before insert expected 4 (insert seen %b)", n_ret, got); end
    checks++; if (a !== '0 || del !== 1'b0) begin failures++; $display("FAIL starve_insert_addr: got addr=%0d delete=%b expected 0 0", a, del); end
    tick(); tick(); tick();
    checks++; if (bus.occupancy !== OCC_WIDTH'(8) || bus.full !== 1'b1) begin failures++; $display("FAIL starve_occupancy: got %0d full=%b expected 8 1", bus.occupancy, bus.full); end
  endtask

  initial begin
    rst = 1'b0;
    bus.ins_valid = 1'b0; bus.ins_data = '0;
    bus.ret_valid = 1'b0; bus.ret_data = '0;
    bus.qry_valid = 1'b0; bus.qry_data = '0;
    bus.cam_write_busy = 1'b0;
    test_reset();
    test_reset_mid();
    test_insert();
    test_query();
    test_retire_miss();
    test_fill();
    test_starve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
